// File: rtl/watering_scheduler.sv
// watering_scheduler: pump sequencer with a 1 s prescaler, interval wait, pump on-time,
// a cooldown lockout and a manual req/ack request path.
module watering_scheduler #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int UNIT_SEC     = 1,
  parameter int PUMP_SEC     = 2,
  parameter int COOLDOWN_SEC = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic [5:0]       interval_sel,
  input  logic             manual_req,
  output logic             manual_ack,
  output logic             pump_on,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] secs_left
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, PUMP = 2'b10, COOL = 2'b11} st_t;
  st_t state_q, state_d;
  logic [CNT_W-1:0] secs_q, secs_d;
  logic [PW-1:0] pre_q, pre_d;
  logic armed_q, armed_d, man_q, man_d, ack_q, ack_d, pump_q, pump_d;
  logic tick, auto_ok, accept, last;
  logic [5:0] sel_c;
  logic [CNT_W-1:0] load, exit_secs;
  st_t exit_st;
  assign tick      = pre_q == PW'(CLK_HZ - 1);
  assign auto_ok   = enable && interval_sel != 6'd0;
  assign sel_c     = interval_sel > 6'd24 ? 6'd24 : interval_sel;
  assign load      = CNT_W'(sel_c) * CNT_W'(UNIT_SEC);
  assign exit_st   = auto_ok ? WAIT : IDLE;
  assign exit_secs = auto_ok ? load : '0;
  assign accept    = manual_req && armed_q && (state_q == IDLE || state_q == WAIT);
  assign last      = tick && secs_q == CNT_W'(1);
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      secs_q  <= '0;
      pre_q   <= '0;
      armed_q <= 1'b1;
      man_q   <= 1'b0;
      ack_q   <= 1'b0;
      pump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      pre_q   <= pre_d;
      armed_q <= armed_d;
      man_q   <= man_d;
      ack_q   <= ack_d;
      pump_q  <= pump_d;
    end
  end
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    man_d   = man_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PUMP;
          secs_d  = CNT_W'(PUMP_SEC);
          man_d   = 1'b1;
        end else if (auto_ok) begin
          state_d = WAIT;
          secs_d  = load;
        end
      end
      WAIT: begin
        if (accept) begin
          state_d = PUMP;
          secs_d  = CNT_W'(PUMP_SEC);
          man_d   = 1'b1;
        end else if (!auto_ok) begin
          state_d = IDLE;
          secs_d  = '0;
        end else if (last) begin
          state_d = PUMP;
          secs_d  = CNT_W'(PUMP_SEC);
          man_d   = 1'b0;
        end else if (tick) begin
          secs_d = secs_q - CNT_W'(1);
        end
      end
      PUMP: begin
        // an auto run aborts on enable drop; a manual run always completes
        if ((!enable && !man_q) || last) begin
          state_d = COOLDOWN_SEC > 0 ? COOL : exit_st;
          secs_d  = COOLDOWN_SEC > 0 ? CNT_W'(COOLDOWN_SEC) : exit_secs;
        end else if (tick) begin
          secs_d = secs_q - CNT_W'(1);
        end
      end
      default: begin
        if (last) begin
          state_d = exit_st;
          secs_d  = exit_secs;
        end else if (tick) begin
          secs_d = secs_q - CNT_W'(1);
        end
      end
    endcase
  end
  always_comb begin
    pre_d   = (state_d != state_q || tick) ? '0 : pre_q + PW'(1);
    armed_d = accept ? 1'b0 : (!manual_req || armed_q);
    ack_d   = accept;
    pump_d  = state_d == PUMP;
  end
  assign manual_ack = ack_q;
  assign pump_on    = pump_q;
  assign state      = state_q;
  assign secs_left  = secs_q;
endmodule

// File: tb/tb_watering_scheduler.sv
// tb_watering_scheduler: directed checks of the scheduler with a 4-cycle second.
module tb_watering_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, manual_req = 1'b0;
  logic [5:0] interval_sel = 6'd0;
  logic manual_ack, pump_on;
  logic [1:0] state;
  logic [15:0] secs_left;
  int total = 0, bad = 0;
  localparam logic [1:0] S_IDLE = 2'b00, S_WAIT = 2'b01, S_PUMP = 2'b10, S_COOL = 2'b11;
  watering_scheduler #(.CLK_HZ(4), .UNIT_SEC(1), .PUMP_SEC(2), .COOLDOWN_SEC(3), .CNT_W(16)) dut (
    .CLOCK_50(clk), .reset(rst_n), .enable(enable), .interval_sel(interval_sel),
    .manual_req(manual_req), .manual_ack(manual_ack), .pump_on(pump_on),
    .state(state), .secs_left(secs_left)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic dur(input logic [1:0] s, input int n, input string tag);
    int c = 0;
    while (state == s && c < 200) begin
      c++;
      @(negedge clk);
    end
    check(tag, c, n);
  endtask
  task automatic look(input string tag, input logic [1:0] s, input int secs, input logic p);
    check({tag, "_state"}, state, s);
    check({tag, "_secs"}, secs_left, secs);
    check({tag, "_pump"}, pump_on, p);
  endtask
  initial begin
    int acks, pumps;
    repeat (2) @(negedge clk);
    look("rst", S_IDLE, 0, 1'b0);
    check("rst_ack", manual_ack, 0);
    rst_n = 1'b1; enable = 1'b1; interval_sel = 6'd3;
    @(negedge clk);
    look("t1_wait", S_WAIT, 3, 1'b0);
    dur(S_WAIT, 12, "t1_wait_len");
    look("t1_pump", S_PUMP, 2, 1'b1);
    dur(S_PUMP, 8, "t1_pump_len");
    look("t1_cool", S_COOL, 3, 1'b0);
    dur(S_COOL, 12, "t1_cool_len");
    look("t1_rewait", S_WAIT, 3, 1'b0);
    interval_sel = 6'd0;
    @(negedge clk);
    look("t2_off", S_IDLE, 0, 1'b0);
    interval_sel = 6'd40;
    @(negedge clk);
    look("t2_clamp", S_WAIT, 24, 1'b0);
    interval_sel = 6'd0;
    @(negedge clk);
    look("t2_off2", S_IDLE, 0, 1'b0);
    interval_sel = 6'd3;
    @(negedge clk);
    look("t3_wait", S_WAIT, 3, 1'b0);
    manual_req = 1'b1;
    acks = 0; pumps = 0;
    repeat (24) begin
      @(negedge clk);
      acks += int'(manual_ack);
      pumps += int'(pump_on);
    end
    check("t3_acks", acks, 1);
    check("t3_pumps", pumps, 8);
    check("t3_held_wait", state, S_WAIT);
    manual_req = 1'b0;
    @(negedge clk);
    manual_req = 1'b1;
    @(negedge clk);
    check("t3_reack", manual_ack, 1);
    look("t3_repump", S_PUMP, 2, 1'b1);
    manual_req = 1'b0;
    dur(S_PUMP, 8, "t3_pump_len");
    dur(S_COOL, 12, "t3_cool_len");
    look("t4_wait", S_WAIT, 3, 1'b0);
    repeat (11) @(negedge clk);
    look("t4_last", S_WAIT, 1, 1'b0);
    manual_req = 1'b1;
    @(negedge clk);
    check("t4_ack", manual_ack, 1);
    look("t4_pump", S_PUMP, 2, 1'b1);
    manual_req = 1'b0;
    @(negedge clk);
    check("t4_ack_once", manual_ack, 0);
    dur(S_PUMP, 7, "t4_pump_len");
    look("t4_cool", S_COOL, 3, 1'b0);
    dur(S_COOL, 12, "t4_cool_len");
    look("t5_wait", S_WAIT, 3, 1'b0);
    dur(S_WAIT, 12, "t5_wait_len");
    look("t5_pump", S_PUMP, 2, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    look("t5_abort", S_COOL, 3, 1'b0);
    dur(S_COOL, 12, "t5_cool_len");
    look("t5_idle", S_IDLE, 0, 1'b0);
    manual_req = 1'b1;
    @(negedge clk);
    check("t5_man_ack", manual_ack, 1);
    look("t5_man_pump", S_PUMP, 2, 1'b1);
    manual_req = 1'b0;
    dur(S_PUMP, 8, "t5_man_len");
    dur(S_COOL, 12, "t5_man_cool");
    look("t5_man_idle", S_IDLE, 0, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    look("t6_wait", S_WAIT, 3, 1'b0);
    dur(S_WAIT, 12, "t6_wait_len");
    look("t6_pump", S_PUMP, 2, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    look("t6_async", S_IDLE, 0, 1'b0);
    check("t6_ack", manual_ack, 0);
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      acks += int'(manual_ack);
    end
    check("t6_no_ack", acks, 0);
    look("t6_idle", S_IDLE, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
